// File: rtl/beat_seq_pkg.sv
// rtl/beat_seq_pkg.sv - shared state encoding and width defaults for beat_sequencer
package beat_seq_pkg;

    localparam int DEF_BEAT_W  = 12;
    localparam int DEF_TEMPO_W = 3;
    localparam int DEF_TRK_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_FADE  = 2'd3
    } seq_state_t;

    // States in which the tone path is audible.
    function automatic logic is_sounding(input seq_state_t s);
        return (s == S_PLAY) || (s == S_FADE);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchroniser plus one-cycle rising-edge pulse
module edge_sync (
    input  logic clk22,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    // sh[0], sh[1] are the synchroniser; sh[2] is the previous synchronised level.
    logic [2:0] sh;

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], d};
        end
    end

    assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - transport controller driving beat index, enable and volume; BEAT_SEQ_FADE_OUT_EN adds stop fade-out
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int BEAT_W  = DEF_BEAT_W,
    parameter int TEMPO_W = DEF_TEMPO_W,
    parameter int TRK_W   = DEF_TRK_W
) (
    input  logic               clk22,
    input  logic               rst,
    input  logic               play_req,
    input  logic               pause_req,
    input  logic               stop_req,
    input  logic               loop_en,
    input  logic [TRK_W-1:0]   track_sel,
    input  logic [BEAT_W-1:0]  track_len,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic [1:0]         vol_set,
    output logic [BEAT_W-1:0]  ibeat_num,
    output logic               en,
    output logic [1:0]         volume,
    output logic [TRK_W-1:0]   track_id,
    output logic               playing,
    output logic               wrap,
    output logic               done
);

    logic play_p, pause_p, stop_p;

    edge_sync u_play_sync  (.clk22(clk22), .rst(rst), .d(play_req),  .pulse(play_p));
    edge_sync u_pause_sync (.clk22(clk22), .rst(rst), .d(pause_req), .pulse(pause_p));
    edge_sync u_stop_sync  (.clk22(clk22), .rst(rst), .d(stop_req),  .pulse(stop_p));

    seq_state_t         state, state_n;
    logic [BEAT_W-1:0]  len_q, len_n, beat_n;
    logic [TEMPO_W-1:0] tick_cnt, tick_n;
    logic [TRK_W-1:0]   trk_n;
    logic [1:0]         vol_n;
    logic               en_n, wrap_n, done_n;
    logic               tick_hit, advance, to_idle;
`ifdef BEAT_SEQ_FADE_OUT_EN
    logic               fade_exit, fade_exit_n;
`endif

    always_comb begin
        state_n  = state;
        beat_n   = ibeat_num;
        en_n     = en;
        vol_n    = volume;
        trk_n    = track_id;
        len_n    = len_q;
        tick_n   = tick_cnt;
        wrap_n   = 1'b0;
        done_n   = 1'b0;
        to_idle  = 1'b0;
        advance  = 1'b0;
`ifdef BEAT_SEQ_FADE_OUT_EN
        fade_exit_n = 1'b0;
`endif
        // >= so a tempo lowered below the running count fires at once instead of wrapping.
        tick_hit = (tick_cnt >= tempo);

        case (state)
            S_IDLE: begin
                en_n   = 1'b0;
                beat_n = '0;
                vol_n  = 2'd0;
                if (play_p) begin
                    state_n = S_PLAY;
                    trk_n   = track_sel;
                    len_n   = track_len;
                    tick_n  = '0;
                    en_n    = 1'b1;
                    vol_n   = vol_set;
                end
            end
            S_PLAY: begin
                if (stop_p) begin
`ifdef BEAT_SEQ_FADE_OUT_EN
                    state_n     = S_FADE;
                    fade_exit_n = (volume == 2'd0);
`else
                    to_idle = 1'b1;
`endif
                end else if (pause_p) begin
                    state_n = S_PAUSE;
                    en_n    = 1'b0;
                end else begin
                    vol_n   = vol_set;
                    advance = tick_hit;
                    tick_n  = tick_hit ? '0 : tick_cnt + TEMPO_W'(1);
                end
            end
            S_PAUSE: begin
                if (stop_p) begin
                    to_idle = 1'b1;
                end else if (pause_p || play_p) begin
                    state_n = S_PLAY;
                    en_n    = 1'b1;
                    vol_n   = vol_set;
                end
            end
`ifdef BEAT_SEQ_FADE_OUT_EN
            S_FADE: begin
                if (stop_p) begin
                    to_idle = 1'b1;
                end else if (play_p) begin
                    state_n = S_PLAY;
                    vol_n   = vol_set;
                end else if (fade_exit) begin
                    to_idle = 1'b1;
                end else if (tick_hit) begin
                    tick_n = '0;
                    if (volume == 2'd0) begin
                        to_idle = 1'b1;
                    end else begin
                        vol_n   = volume - 2'd1;
                        advance = 1'b1;
                    end
                end else begin
                    tick_n = tick_cnt + TEMPO_W'(1);
                end
            end
`endif
            default: to_idle = 1'b1;
        endcase

        if (advance) begin
            if (ibeat_num < len_q) begin
                beat_n = ibeat_num + BEAT_W'(1);
            end else begin
                beat_n = '0;
                if (loop_en) begin
                    wrap_n = 1'b1;
                end else begin
                    done_n  = 1'b1;
                    to_idle = 1'b1;
                end
            end
        end

        if (to_idle) begin
            state_n = S_IDLE;
            en_n    = 1'b0;
            beat_n  = '0;
            vol_n   = 2'd0;
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ibeat_num <= '0;
            en        <= 1'b0;
            volume    <= 2'd0;
            track_id  <= '0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            len_q     <= '0;
        end else begin
            state     <= state_n;
            ibeat_num <= beat_n;
            en        <= en_n;
            volume    <= vol_n;
            track_id  <= trk_n;
            wrap      <= wrap_n;
            done      <= done_n;
            tick_cnt  <= tick_n;
            len_q     <= len_n;
        end
    end

`ifdef BEAT_SEQ_FADE_OUT_EN
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            fade_exit <= 1'b0;
        end else begin
            fade_exit <= fade_exit_n;
        end
    end
`endif

    assign playing = is_sounding(state);

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - scoreboard bench for beat_sequencer against a behavioural transport model
module tb_beat_sequencer;

    localparam int BEAT_W  = 12;
    localparam int TEMPO_W = 3;
    localparam int TRK_W   = 2;

    logic               clk22 = 1'b0;
    logic               rst = 1'b1;
    logic               play_req = 1'b0, pause_req = 1'b0, stop_req = 1'b0, loop_en = 1'b0;
    logic [TRK_W-1:0]   track_sel = '0;
    logic [BEAT_W-1:0]  track_len = '0;
    logic [TEMPO_W-1:0] tempo = '0;
    logic [1:0]         vol_set = 2'd0;
    logic [BEAT_W-1:0]  ibeat_num;
    logic               en, playing, wrap, done;
    logic [1:0]         volume;
    logic [TRK_W-1:0]   track_id;

    beat_sequencer #(.BEAT_W(BEAT_W), .TEMPO_W(TEMPO_W), .TRK_W(TRK_W)) dut (
        .clk22(clk22), .rst(rst), .play_req(play_req), .pause_req(pause_req),
        .stop_req(stop_req), .loop_en(loop_en), .track_sel(track_sel),
        .track_len(track_len), .tempo(tempo), .vol_set(vol_set),
        .ibeat_num(ibeat_num), .en(en), .volume(volume), .track_id(track_id),
        .playing(playing), .wrap(wrap), .done(done)
    );

    always #5 clk22 = ~clk22;

    typedef struct packed {
        logic [BEAT_W-1:0] beat;
        logic              en;
        logic [1:0]        vol;
        logic [TRK_W-1:0]  trk;
        logic              playing;
        logic              wrap;
        logic              done;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Transport model: mode, beat position, ticks since last beat, latched track.
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_FADE = 3;
    int m_mode = M_IDLE, m_beat = 0, m_ticks = 0, m_len = 0, m_trk = 0, m_vol = 0;
    bit m_wrap = 0, m_done = 0, m_exit = 0;
    bit hist[3][4];

    task automatic model_step();
        bit lvl[3];
        bit rise[3];
        bit go_idle, adv, was_exit;
        lvl[0] = play_req; lvl[1] = pause_req; lvl[2] = stop_req;
        m_wrap = 0; m_done = 0; go_idle = 0; adv = 0;
        was_exit = m_exit; m_exit = 0;
        if (rst) begin
            m_mode = M_IDLE; m_beat = 0; m_ticks = 0; m_len = 0; m_trk = 0; m_vol = 0;
            for (int r = 0; r < 3; r++) for (int a = 0; a < 4; a++) hist[r][a] = 0;
            return;
        end
        // A request level rise is acted on two clock edges after it is first sampled.
        for (int r = 0; r < 3; r++) begin
            for (int a = 3; a > 0; a--) hist[r][a] = hist[r][a-1];
            hist[r][0] = lvl[r];
            rise[r] = hist[r][2] && !hist[r][3];
        end
        case (m_mode)
            M_IDLE: if (rise[0]) begin
                m_mode = M_PLAY; m_trk = int'(track_sel); m_len = int'(track_len);
                m_beat = 0; m_ticks = 0; m_vol = int'(vol_set);
            end
            M_PLAY: begin
                if (rise[2]) begin
`ifdef BEAT_SEQ_FADE_OUT_EN
                    m_mode = M_FADE; m_exit = (m_vol == 0);
`else
                    go_idle = 1;
`endif
                end else if (rise[1]) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_vol = int'(vol_set);
                    if (m_ticks >= int'(tempo)) begin m_ticks = 0; adv = 1; end
                    else m_ticks++;
                end
            end
            M_PAUSE: begin
                if (rise[2]) go_idle = 1;
                else if (rise[1] || rise[0]) begin m_mode = M_PLAY; m_vol = int'(vol_set); end
            end
            default: begin
                if (rise[2]) go_idle = 1;
                else if (rise[0]) begin m_mode = M_PLAY; m_vol = int'(vol_set); end
                else if (was_exit) go_idle = 1;
                else if (m_ticks >= int'(tempo)) begin
                    m_ticks = 0;
                    if (m_vol == 0) go_idle = 1;
                    else begin m_vol--; adv = 1; end
                end else m_ticks++;
            end
        endcase
        if (adv) begin
            if (m_beat < m_len) m_beat++;
            else begin
                m_beat = 0;
                if (loop_en) m_wrap = 1;
                else begin m_done = 1; go_idle = 1; end
            end
        end
        if (go_idle) begin m_mode = M_IDLE; m_beat = 0; m_vol = 0; end
    endtask

    task automatic tick();
        obs_t e;
        model_step();
        e.beat    = BEAT_W'(m_beat);
        e.en      = (m_mode == M_PLAY) || (m_mode == M_FADE);
        e.vol     = 2'(m_vol);
        e.trk     = TRK_W'(m_trk);
        e.playing = e.en;
        e.wrap    = m_wrap;
        e.done    = m_done;
        exp_q.push_back(e);
        @(negedge clk22);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic rise_req(input bit p, input bit pa, input bit s);
        if (p)  play_req  = 1'b1;
        if (pa) pause_req = 1'b1;
        if (s)  stop_req  = 1'b1;
        tick(); tick();
        play_req = 1'b0; pause_req = 1'b0; stop_req = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_beat(input int target, input int limit, input string nm);
        int k = 0;
        while (!(m_beat == target && m_mode == M_PLAY) && k < limit) begin tick(); k++; end
        chk(nm, int'(m_beat == target && m_mode == M_PLAY), 1);
    endtask

    initial begin : monitor
        obs_t a, e;
        forever begin
            @(posedge clk22);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {ibeat_num, en, volume, track_id, playing, wrap, done};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL obs t=%0t got beat=%0d en=%0b vol=%0d trk=%0d ply=%0b wrap=%0b done=%0b, expected beat=%0d en=%0b vol=%0d trk=%0d ply=%0b wrap=%0b done=%0b",
                             $time, a.beat, a.en, a.vol, a.trk, a.playing, a.wrap, a.done,
                             e.beat, e.en, e.vol, e.trk, e.playing, e.wrap, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        int wc, dc, exp_ply;
        @(negedge clk22);
        run(3);
        chk("reset_en", int'(en), 0);
        chk("reset_beat", int'(ibeat_num), 0);
        rst = 1'b0;

        // One-shot, tempo 0.
        track_len = 12'd5; tempo = 3'd0; loop_en = 1'b0; vol_set = 2'd2; track_sel = 2'd1;
        rise_req(1, 0, 0);
        chk("start_lat2_en", int'(en), 0);
        tick();
        chk("start_lat3_en", int'(en), 1);
        chk("start_vol", int'(volume), 2);
        run(5);
        chk("oneshot_last_beat", int'(ibeat_num), 5);
        tick();
        chk("oneshot_done", int'(done), 1);
        chk("oneshot_en_off", int'(en), 0);
        run(3);

        // Loop with divider.
        track_len = 12'd3; tempo = 3'd2; loop_en = 1'b1; track_sel = 2'd2;
        rise_req(1, 0, 0);
        tick();
        wc = 0; dc = 0;
        repeat (36) begin tick(); wc += int'(wrap); dc += int'(done); end
        chk("loop_wraps", wc, 3);
        chk("loop_no_done", dc, 0);
        rise_req(0, 0, 1);
        run(20);

        // Pause and resume.
        track_len = 12'd20; tempo = 3'd3; loop_en = 1'b0;
        rise_req(1, 0, 0);
        wait_beat(7, 60, "wait_beat7");
        rise_req(0, 1, 0);
        tick();
        chk("pause_en", int'(en), 0);
        run(20);
        chk("pause_hold", int'(ibeat_num), 7);
        rise_req(0, 1, 0);
        tick();
        chk("resume_en", int'(en), 1);
        wait_beat(8, 10, "resume_beat8");
        run(80);

        // Simultaneous edges.
        rise_req(1, 0, 0);
        run(6);
        rise_req(0, 1, 1);
        tick();
`ifdef BEAT_SEQ_FADE_OUT_EN
        exp_ply = 1;
`else
        exp_ply = 0;
`endif
        chk("stop_beats_pause", int'(playing), exp_ply);
        run(40);
        rise_req(1, 1, 0);
        tick();
        chk("play_beats_pause", int'(playing), 1);
        rise_req(0, 0, 1);
        run(40);

        // Asynchronous reset mid-play.
        track_len = 12'd200; tempo = 3'd0; track_sel = 2'd3;
        rise_req(1, 0, 0);
        wait_beat(100, 150, "wait_beat100");
        rst = 1'b1;
        #1;
        chk("arst_beat", int'(ibeat_num), 0);
        chk("arst_en", int'(en), 0);
        chk("arst_trk", int'(track_id), 0);
        chk("arst_ply", int'(playing), 0);
        tick();
        rst = 1'b0;
        rise_req(1, 0, 0);
        tick();
        chk("restart_beat", int'(ibeat_num), 0);
        chk("restart_en", int'(en), 1);

        // Stop from PLAY at full volume.
        track_len = 12'd50; loop_en = 1'b1; vol_set = 2'd3;
        run(5);
        rise_req(0, 0, 1);
        tick();
`ifdef BEAT_SEQ_FADE_OUT_EN
        chk("fade_entry_vol", int'(volume), 3);
        tick(); chk("fade_vol2", int'(volume), 2);
        tick(); chk("fade_vol1", int'(volume), 1);
        tick(); chk("fade_vol0", int'(volume), 0);
        tick(); chk("fade_end_en", int'(en), 0);
`else
        chk("stop_en_off", int'(en), 0);
`endif
        run(5);

        // Randomised traffic.
        repeat (3000) begin
            if ($urandom_range(99) < 3) play_req  = ~play_req;
            if ($urandom_range(99) < 2) pause_req = ~pause_req;
            if ($urandom_range(199) < 3) stop_req = ~stop_req;
            if ($urandom_range(99) < 1) loop_en   = ~loop_en;
            if ($urandom_range(99) < 2) tempo     = TEMPO_W'($urandom_range(7));
            if ($urandom_range(99) < 5) vol_set   = 2'($urandom_range(3));
            track_len = BEAT_W'($urandom_range(15));
            track_sel = TRK_W'($urandom_range(3));
            tick();
        end

        play_req = 1'b0; pause_req = 1'b0; stop_req = 1'b0;
        run(5);
        repeat (2) @(posedge clk22);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
